led_scan_arbiter: RTL and testbench
===================================

LED_SCAN_ARBITER -- requirements
Module: led_scan_arbiter

Interface
REQ-001 Parameter DWELL, default 2000, clock cycles each pixel (or blank slot) is held on LEDout; legal range 1..2^22-1.
REQ-002 Parameter BLANK_SLOTS, default 8, number of dwell periods of blank output at end of each frame; legal range 1..255.
REQ-003 Reset RSTn, asynchronous, active-low; clock CLK.
REQ-004 CLK  input  1  system clock.
REQ-005 RSTn  input  1  asynchronous active-low reset.
REQ-006 en  input  1  scan enable, sampled only at frame boundaries.
REQ-007 req_valid  input  4  per-requester sprite present flag, bit i = requester i.
REQ-008 req_x  input  12  sprite start column, 3 bits per requester, [3i+2:3i].
REQ-009 req_y  input  16  sprite row, 4 bits per requester, [4i+3:4i].
REQ-010 req_len  input  8  sprite length minus 1 (1..4 pixels, horizontal), 2 bits per requester.
REQ-011 req_color  input  8  sprite colour code, 2 bits per requester.
REQ-012 req_ack  output  4  one-cycle pulse, bit i: requester i parameters sampled.
REQ-013 LEDout  output  10  {color[1:0], 1'b0, y[3:0], x[2:0]}; all-zero = dark.
REQ-014 frame_start  output  1  one-cycle pulse at start of each frame.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 States: IDLE, SCAN, DRAW, BLANK; all outputs registered.
REQ-017 IDLE: LEDout=0; when en=1, next state SCAN with idx=0 and frame_start pulsed for that same cycle.
REQ-018 SCAN, req_valid[idx]=1: req_ack[idx]=1 this cycle; latch x,y,len,color of idx; next state DRAW, pix=0.
REQ-019 SCAN, req_valid[idx]=0: skip in one cycle; idx<3 -> SCAN idx+1, idx=3 -> BLANK.
REQ-020 Requester inputs are sampled only in the ack cycle; later changes do not affect the sprite being drawn.
REQ-021 DRAW: the cycle after ack, LEDout={color,0,y,x+pix}, held exactly DWELL cycles per pixel, pix=0..len.
REQ-022 Column arithmetic 4-bit: x+pix>7 yields LEDout=0 for that slot (clipped, no wrap), slot still consumes DWELL cycles.
REQ-023 After the last pixel: idx<3 -> SCAN idx+1, idx=3 -> BLANK; LEDout=0 in every SCAN cycle.
REQ-024 BLANK: LEDout=0 for BLANK_SLOTS*DWELL cycles; then en=1 -> SCAN idx=0 with frame_start, en=0 -> IDLE.
REQ-025 en deasserted mid-frame: current frame completes including BLANK, then IDLE.
REQ-026 Fixed order 0,1,2,3 per frame; each requester drawn at most once per frame; no starvation.
REQ-027 Dwell counter counts 0..DWELL-1 and restarts at each pixel/blank slot; DWELL=1 gives one cycle per pixel.

Reset
REQ-028 RSTn low: state IDLE, idx=0, pix=0, dwell counter 0, LEDout=0, req_ack=0, frame_start=0, busy=0, latched sprite regs 0.
REQ-029 Reset asserted mid-DRAW aborts immediately; no ack or frame_start is emitted until en is seen after release.

Structure
REQ-030 Shared package holds state encoding, LEDout field positions/widths, N_REQ=4, per-requester field widths.
REQ-031 One sub-module scan_dwell_timer (counter with DWELL parameter, restart input, terminal-count output).

Verification (DWELL=4, BLANK_SLOTS=2 on bench)
REQ-032 Reset, en=1, only req0 valid x=2 y=12 len=2 color=2'b10 -> ack0 once, LEDout 10'b10_0_1100_010, _011, _100 for 4 cycles each, then 8 cycles of 0, frame_start again.
REQ-033 req1 x=6 len=3 y=3 color=01 -> columns 6,7 lit for 4 cycles each, then two 4-cycle zero slots (clipped), no wrap to column 0.
REQ-034 All four valid, len=0 -> ack order 0,1,2,3, each pixel 4 cycles, frame length = 4 SCAN + 16 DRAW + 8 BLANK = 28 cycles between frame_start pulses.
REQ-035 Change req_x of req0 during its DRAW -> current sprite unchanged; new x appears next frame.
REQ-036 Drop en mid-DRAW of req1 -> frame completes, busy falls after BLANK, no further frame_start; RSTn pulse mid-DRAW -> LEDout=0 next cycle, IDLE.

Source files
------------

// File: rtl/led_scan_arbiter_pkg.sv
// Shared definitions for the LED scan arbiter: FSM states, LED word layout and
// per-requester field widths.
package led_scan_arbiter_pkg;

    localparam int N_REQ   = 4;
    localparam int IDX_W   = 2;
    localparam int X_W     = 3;
    localparam int Y_W     = 4;
    localparam int LEN_W   = 2;
    localparam int COLOR_W = 2;
    localparam int COL_W   = 4;
    localparam int DWELL_W = 22;
    localparam int BLANK_W = 8;

    localparam int LED_W         = 10;
    localparam int LED_X_LSB     = 0;
    localparam int LED_Y_LSB     = 3;
    localparam int LED_PAD_BIT   = 7;
    localparam int LED_COLOR_LSB = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAW  = 2'd2,
        ST_BLANK = 2'd3
    } state_t;

    // A column past 7 is clipped to a dark word rather than wrapping to column 0.
    function automatic logic [LED_W-1:0] pixel_word(
        input logic [COLOR_W-1:0] color,
        input logic [Y_W-1:0]     y,
        input logic [X_W-1:0]     x,
        input logic [LEN_W-1:0]   pix
    );
        logic [COL_W-1:0] col;
        logic [LED_W-1:0] word;
        col  = COL_W'(x) + COL_W'(pix);
        word = '0;
        if (!col[X_W]) begin
            word[LED_X_LSB +: X_W]         = col[X_W-1:0];
            word[LED_Y_LSB +: Y_W]         = y;
            word[LED_PAD_BIT]              = 1'b0;
            word[LED_COLOR_LSB +: COLOR_W] = color;
        end
        return word;
    endfunction

endpackage

// File: rtl/led_scan_arbiter_dwell_timer.sv
// Dwell timer: counts 0..DWELL-1 while enabled, flags the last cycle of each slot.
module scan_dwell_timer
    import led_scan_arbiter_pkg::*;
#(
    parameter int DWELL = 2000
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic restart,
    output logic tc
);

    logic [DWELL_W-1:0] cnt_q;
    logic [DWELL_W-1:0] cnt_d;
    logic               at_end;

    assign at_end = (cnt_q == DWELL_W'(DWELL - 1));
    assign tc     = at_end && !restart;

    always_comb begin
        cnt_d = cnt_q + DWELL_W'(1);
        if (restart || at_end) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_scan_arbiter.sv
// Round-robin sprite scanner: visits requesters 0..3 once per frame, draws each
// sprite pixel for DWELL cycles, then blanks the display before the next frame.
module led_scan_arbiter
    import led_scan_arbiter_pkg::*;
#(
    parameter int DWELL       = 2000,
    parameter int BLANK_SLOTS = 8
) (
    input  logic                     CLK,
    input  logic                     RSTn,
    input  logic                     en,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*X_W-1:0]     req_x,
    input  logic [N_REQ*Y_W-1:0]     req_y,
    input  logic [N_REQ*LEN_W-1:0]   req_len,
    input  logic [N_REQ*COLOR_W-1:0] req_color,
    output logic [N_REQ-1:0]         req_ack,
    output logic [LED_W-1:0]         LEDout,
    output logic                     frame_start,
    output logic                     busy
);

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [LEN_W-1:0]     pix_q, pix_d;
    logic [BLANK_W-1:0]   blank_q, blank_d;
    logic [X_W-1:0]       x_q, x_d;
    logic [Y_W-1:0]       y_q, y_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [COLOR_W-1:0]   color_q, color_d;
    logic [N_REQ-1:0]     ack_q, ack_d;
    logic [LED_W-1:0]     led_q, led_d;
    logic                 frame_start_q, frame_start_d;
    logic                 busy_q, busy_d;
    logic                 enter_scan;
    logic                 last_req;
    logic                 restart;
    logic                 tc;

    assign restart  = !((state_q == ST_DRAW) || (state_q == ST_BLANK));
    assign last_req = (idx_q == IDX_W'(N_REQ - 1));

    scan_dwell_timer #(
        .DWELL(DWELL)
    ) u_timer (
        .CLK    (CLK),
        .RSTn   (RSTn),
        .restart(restart),
        .tc     (tc)
    );

    // Outputs are computed from the next state so the ack lands in the SCAN
    // cycle and the first pixel in the cycle right after it.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        pix_d      = pix_q;
        blank_d    = blank_q;
        enter_scan = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d    = ST_SCAN;
                    idx_d      = '0;
                    enter_scan = 1'b1;
                end
            end
            ST_SCAN: begin
                if (|ack_q) begin
                    state_d = ST_DRAW;
                    pix_d   = '0;
                end else if (last_req) begin
                    state_d = ST_BLANK;
                    blank_d = '0;
                end else begin
                    idx_d      = idx_q + IDX_W'(1);
                    enter_scan = 1'b1;
                end
            end
            ST_DRAW: begin
                if (tc) begin
                    if (pix_q != len_q) begin
                        pix_d = pix_q + LEN_W'(1);
                    end else if (last_req) begin
                        state_d = ST_BLANK;
                        blank_d = '0;
                    end else begin
                        state_d    = ST_SCAN;
                        idx_d      = idx_q + IDX_W'(1);
                        enter_scan = 1'b1;
                    end
                end
            end
            ST_BLANK: begin
                if (tc) begin
                    if (blank_q != BLANK_W'(BLANK_SLOTS - 1)) begin
                        blank_d = blank_q + BLANK_W'(1);
                    end else if (en) begin
                        state_d    = ST_SCAN;
                        idx_d      = '0;
                        enter_scan = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        ack_d   = '0;
        x_d     = x_q;
        y_d     = y_q;
        len_d   = len_q;
        color_d = color_q;
        if (enter_scan && req_valid[idx_d]) begin
            ack_d[idx_d] = 1'b1;
            x_d          = req_x[idx_d*X_W +: X_W];
            y_d          = req_y[idx_d*Y_W +: Y_W];
            len_d        = req_len[idx_d*LEN_W +: LEN_W];
            color_d      = req_color[idx_d*COLOR_W +: COLOR_W];
        end

        frame_start_d = enter_scan && (idx_d == '0);
        busy_d        = (state_d != ST_IDLE);
        led_d         = (state_d == ST_DRAW) ? pixel_word(color_q, y_q, x_q, pix_d) : '0;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            pix_q         <= '0;
            blank_q       <= '0;
            x_q           <= '0;
            y_q           <= '0;
            len_q         <= '0;
            color_q       <= '0;
            ack_q         <= '0;
            led_q         <= '0;
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            pix_q         <= pix_d;
            blank_q       <= blank_d;
            x_q           <= x_d;
            y_q           <= y_d;
            len_q         <= len_d;
            color_q       <= color_d;
            ack_q         <= ack_d;
            led_q         <= led_d;
            frame_start_q <= frame_start_d;
            busy_q        <= busy_d;
        end
    end

    assign req_ack     = ack_q;
    assign LEDout      = led_q;
    assign frame_start = frame_start_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_led_scan_arbiter.sv
// Self-checking bench for led_scan_arbiter: a segment-level frame model checks
// every cycle, directed scenarios pin literal LED words and frame periods.
module tb_led_scan_arbiter;

    localparam int DWELL       = 4;
    localparam int BLANK_SLOTS = 2;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        en;
    logic [3:0]  req_valid;
    logic [11:0] req_x;
    logic [15:0] req_y;
    logic [7:0]  req_len;
    logic [7:0]  req_color;
    logic [3:0]  req_ack;
    logic [9:0]  LEDout;
    logic        frame_start;
    logic        busy;

    int errors   = 0;
    int checks   = 0;
    int cyc      = 0;
    int fs_count = 0;
    int ack_log[$];

    typedef struct packed {
        logic [3:0] ack;
        logic [9:0] led;
        logic       fs;
        logic       busy;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp_cur  = '0;
    bit   in_frame = 1'b0;
    int   next_idx = 0;

    led_scan_arbiter #(
        .DWELL      (DWELL),
        .BLANK_SLOTS(BLANK_SLOTS)
    ) dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .en         (en),
        .req_valid  (req_valid),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_len    (req_len),
        .req_color  (req_color),
        .req_ack    (req_ack),
        .LEDout     (LEDout),
        .frame_start(frame_start),
        .busy       (busy)
    );

    initial forever #5 CLK = ~CLK;

    function automatic exp_t mk(input logic [3:0] a, input logic [9:0] l,
                                input logic f, input logic b);
        exp_t e;
        e.ack  = a;
        e.led  = l;
        e.fs   = f;
        e.busy = b;
        return e;
    endfunction

    // One requester visit: a scan cycle, then (len+1) pixels of DWELL cycles each.
    task automatic planScan(input int i, input logic fs);
        logic [2:0] x;
        logic [3:0] y;
        logic [1:0] ln;
        logic [1:0] c;
        logic [9:0] led;
        int col;
        exp_q.push_back(mk(req_valid[i] ? 4'(1 << i) : 4'd0, 10'd0, fs, 1'b1));
        if (req_valid[i]) begin
            x  = req_x[3*i +: 3];
            y  = req_y[4*i +: 4];
            ln = req_len[2*i +: 2];
            c  = req_color[2*i +: 2];
            for (int p = 0; p <= int'(ln); p++) begin
                col = int'(x) + p;
                led = (col > 7) ? 10'd0 : {c, 1'b0, y, 3'(col)};
                repeat (DWELL) exp_q.push_back(mk(4'd0, led, 1'b0, 1'b1));
            end
        end
        next_idx = i + 1;
    endtask

    task automatic planSegment();
        if (!in_frame) begin
            if (en) begin
                in_frame = 1'b1;
                planScan(0, 1'b1);
            end else begin
                exp_q.push_back(mk(4'd0, 10'd0, 1'b0, 1'b0));
            end
        end else if (next_idx == 4) begin
            repeat (BLANK_SLOTS * DWELL) exp_q.push_back(mk(4'd0, 10'd0, 1'b0, 1'b1));
            in_frame = 1'b0;
        end else begin
            planScan(next_idx, 1'b0);
        end
    endtask

    initial forever begin
        @(posedge CLK);
        cyc++;
        if (!RSTn) begin
            exp_q.delete();
            in_frame = 1'b0;
            next_idx = 0;
            exp_cur  = '0;
        end else begin
            if (exp_q.size() == 0) planSegment();
            exp_cur = exp_q.pop_front();
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h",
                     name, cyc, actual, expected);
        end
    endtask

    initial forever begin
        @(negedge CLK);
        checkOutput("model req_ack", 32'(req_ack), 32'(exp_cur.ack));
        checkOutput("model LEDout", 32'(LEDout), 32'(exp_cur.led));
        checkOutput("model frame_start", 32'(frame_start), 32'(exp_cur.fs));
        checkOutput("model busy", 32'(busy), 32'(exp_cur.busy));
        if (frame_start === 1'b1) fs_count++;
        for (int i = 0; i < 4; i++) begin
            if (req_ack[i] === 1'b1) ack_log.push_back(i);
        end
    end

    task automatic stepCycles(input int n);
        repeat (n) begin
            @(negedge CLK);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic e, input logic [3:0] v, input logic [11:0] x,
                                 input logic [15:0] y, input logic [7:0] l,
                                 input logic [7:0] c);
        en        = e;
        req_valid = v;
        req_x     = x;
        req_y     = y;
        req_len   = l;
        req_color = c;
    endtask

    task automatic waitFrameStart(input string name, output int stamp);
        int n = 0;
        do begin
            stepCycles(1);
            n++;
        end while (frame_start !== 1'b1 && n < 200);
        if (frame_start !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: frame_start not seen, got 0 after %0d cycles, expected 1", name, n);
        end
        stamp = cyc;
    endtask

    task automatic waitAck(input string name, input int idx);
        int n = 0;
        do begin
            stepCycles(1);
            n++;
        end while (req_ack[idx] !== 1'b1 && n < 200);
        if (req_ack[idx] !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: ack not seen, got 0 after %0d cycles, expected 1", name, n);
        end
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < 200) begin
            stepCycles(1);
            n++;
        end
        if (busy !== 1'b0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: busy still 1 after %0d cycles, expected 0", name, n);
        end
    endtask

    initial begin
        int s0;
        int s1;
        int fs_before;

        RSTn = 1'b0;
        applyStimulus(1'b0, 4'd0, 12'd0, 16'd0, 8'd0, 8'd0);
        stepCycles(3);
        checkOutput("reset LEDout", 32'(LEDout), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset req_ack", 32'(req_ack), 32'd0);
        checkOutput("reset frame_start", 32'(frame_start), 32'd0);

        $display("[TB] single sprite req0 x=2 y=12 len=2");
        applyStimulus(1'b1, 4'b0001, 12'h002, 16'h000C, 8'h02, 8'h02);
        RSTn = 1'b1;
        waitFrameStart("A first frame", s0);
        checkOutput("A ack0", 32'(req_ack), 32'b0001);
        stepCycles(1);
        checkOutput("A pixel0", 32'(LEDout), 32'(10'b10_0_1100_010));
        stepCycles(4);
        checkOutput("A pixel1", 32'(LEDout), 32'(10'b10_0_1100_011));
        stepCycles(4);
        checkOutput("A pixel2", 32'(LEDout), 32'(10'b10_0_1100_100));
        stepCycles(4);
        checkOutput("A dark after sprite", 32'(LEDout), 32'd0);
        waitFrameStart("A second frame", s1);
        checkOutput("A frame period", 32'(s1 - s0), 32'd24);
        en = 1'b0;
        waitIdle("A idle");

        $display("[TB] clipped sprite req1 x=6 len=3");
        applyStimulus(1'b1, 4'b0010, {3'd0, 3'd0, 3'd6, 3'd0}, {4'd0, 4'd0, 4'd3, 4'd0},
                      {2'd0, 2'd0, 2'd3, 2'd0}, {2'd0, 2'd0, 2'b01, 2'd0});
        waitFrameStart("B first frame", s0);
        checkOutput("B no ack0", 32'(req_ack), 32'd0);
        stepCycles(1);
        checkOutput("B ack1", 32'(req_ack), 32'b0010);
        stepCycles(1);
        checkOutput("B col6", 32'(LEDout), 32'(10'b01_0_0011_110));
        stepCycles(4);
        checkOutput("B col7", 32'(LEDout), 32'(10'b01_0_0011_111));
        stepCycles(4);
        checkOutput("B col8 clipped", 32'(LEDout), 32'd0);
        stepCycles(4);
        checkOutput("B col9 clipped", 32'(LEDout), 32'd0);
        checkOutput("B busy while clipped", 32'(busy), 32'd1);
        waitFrameStart("B second frame", s1);
        checkOutput("B frame period", 32'(s1 - s0), 32'd28);
        en = 1'b0;
        waitIdle("B idle");

        $display("[TB] all four requesters, len=0");
        applyStimulus(1'b1, 4'hF, {3'd7, 3'd5, 3'd3, 3'd0}, {4'd8, 4'd4, 4'd2, 4'd1},
                      8'h00, {2'd1, 2'd3, 2'd2, 2'd1});
        ack_log.delete();
        waitFrameStart("C first frame", s0);
        waitFrameStart("C second frame", s1);
        checkOutput("C frame period", 32'(s1 - s0), 32'd28);
        checkOutput("C ack count", 32'(ack_log.size()), 32'd5);
        for (int k = 0; k < 4; k++) begin
            if (ack_log.size() > k) checkOutput("C ack order", 32'(ack_log[k]), 32'(k));
        end
        en = 1'b0;
        waitIdle("C idle");

        $display("[TB] x change during draw");
        applyStimulus(1'b1, 4'b0001, 12'h001, 16'h0005, 8'h01, 8'h03);
        waitFrameStart("D first frame", s0);
        stepCycles(1);
        checkOutput("D pixel0 old x", 32'(LEDout), 32'(10'b11_0_0101_001));
        stepCycles(1);
        req_x = 12'h005;
        stepCycles(3);
        checkOutput("D pixel1 old x", 32'(LEDout), 32'(10'b11_0_0101_010));
        waitFrameStart("D second frame", s1);
        stepCycles(1);
        checkOutput("D pixel0 new x", 32'(LEDout), 32'(10'b11_0_0101_101));
        en = 1'b0;
        waitIdle("D idle");

        $display("[TB] en drop mid-draw, then reset mid-draw");
        applyStimulus(1'b1, 4'b0011, {3'd0, 3'd0, 3'd2, 3'd4}, {4'd0, 4'd0, 4'd9, 4'd6},
                      {2'd0, 2'd0, 2'd3, 2'd0}, {2'd0, 2'd0, 2'd2, 2'd1});
        waitAck("E ack1", 1);
        stepCycles(2);
        en = 1'b0;
        fs_before = fs_count;
        waitIdle("E idle after frame");
        stepCycles(20);
        checkOutput("E no new frame", 32'(fs_count), 32'(fs_before));
        checkOutput("E busy low", 32'(busy), 32'd0);

        req_len = 8'h03;
        en = 1'b1;
        waitFrameStart("E reset frame", s0);
        stepCycles(3);
        RSTn = 1'b0;
        en   = 1'b0;
        stepCycles(1);
        checkOutput("E reset LEDout", 32'(LEDout), 32'd0);
        checkOutput("E reset busy", 32'(busy), 32'd0);
        checkOutput("E reset req_ack", 32'(req_ack), 32'd0);
        RSTn = 1'b1;
        fs_before = fs_count;
        stepCycles(5);
        checkOutput("E quiet after reset", 32'(fs_count), 32'(fs_before));
        checkOutput("E idle after reset", 32'(busy), 32'd0);
        en = 1'b1;
        waitFrameStart("E restart frame", s1);
        checkOutput("E restart ack0", 32'(req_ack), 32'b0001);

        stepCycles(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
